// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: requests one word at pc, holds it for the execute
// stage, then advances pc (sequential or branch) and counts retired instructions.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int          ACK_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic        instr_valid,
    output logic [31:0] pc,
    input  logic        exec_ready,
    input  logic        pc_src,
    input  logic [31:0] imm_ext,
    output logic        fault,
    output logic [31:0] instret
);

    localparam int TW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
    localparam logic [TW-1:0] TMO_LAST = TW'(ACK_TIMEOUT - 1);
    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        RST_WAIT,
        FETCH,
        ISSUE,
        HALT
    } state_t;

    state_t        state_reg, state_next;
    logic [31:0]   pc_reg, pc_next;
    logic [31:0]   instr_reg, instr_next;
    logic [31:0]   instret_reg, instret_next;
    logic          fault_reg, fault_next;
    logic          valid_reg, valid_next;
    logic [TW-1:0] tmo_reg, tmo_next;
    logic [31:0]   target;

    assign target = pc_src ? (pc_reg + imm_ext) : (pc_reg + 32'd4);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= RST_WAIT;
            pc_reg      <= RESET_PC;
            instr_reg   <= NOP;
            instret_reg <= '0;
            fault_reg   <= 1'b0;
            valid_reg   <= 1'b0;
            tmo_reg     <= '0;
        end else begin
            state_reg   <= state_next;
            pc_reg      <= pc_next;
            instr_reg   <= instr_next;
            instret_reg <= instret_next;
            fault_reg   <= fault_next;
            valid_reg   <= valid_next;
            tmo_reg     <= tmo_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        pc_next      = pc_reg;
        instr_next   = instr_reg;
        instret_next = instret_reg;
        fault_next   = fault_reg;
        tmo_next     = tmo_reg;
        case (state_reg)
            RST_WAIT: begin
                state_next = FETCH;
                tmo_next   = '0;
            end
            FETCH: begin
                // An ack on the final allowed cycle still wins over the timeout.
                if (imem_ack) begin
                    instr_next = imem_rdata;
                    state_next = ISSUE;
                    tmo_next   = '0;
                end else if (tmo_reg == TMO_LAST) begin
                    state_next = HALT;
                    fault_next = 1'b1;
                end else begin
                    tmo_next = tmo_reg + TW'(1);
                end
            end
            ISSUE: begin
                if (exec_ready) begin
                    instret_next = instret_reg + 32'd1;
                    if (target[1:0] != 2'b00) begin
                        state_next = HALT;
                        fault_next = 1'b1;
                    end else begin
                        pc_next    = target;
                        state_next = FETCH;
                        tmo_next   = '0;
                    end
                end
            end
            HALT: begin
                fault_next = 1'b1;
            end
            default: begin
                state_next = HALT;
                fault_next = 1'b1;
            end
        endcase
        valid_next = (state_next == ISSUE);
    end

    // Request is a decode of the state register so reset removes it at once.
    assign imem_req    = (state_reg == FETCH);
    assign imem_addr   = pc_reg;
    assign pc          = pc_reg;
    assign instr       = instr_reg;
    assign instr_valid = valid_reg;
    assign instret     = instret_reg;
    assign fault       = fault_reg;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit: a driver plays memory and execute stage,
// a monitor pops expected {pc, instr, instret} whenever an instruction is issued.
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic [31:0] instr;
    logic        instr_valid;
    logic [31:0] pc;
    logic        exec_ready = 1'b0;
    logic        pc_src = 1'b0;
    logic [31:0] imm_ext = '0;
    logic        fault;
    logic [31:0] instret;

    always #5 clk = ~clk;

    instr_fetch_unit dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .instr      (instr),
        .instr_valid(instr_valid),
        .pc         (pc),
        .exec_ready (exec_ready),
        .pc_src     (pc_src),
        .imm_ext    (imm_ext),
        .fault      (fault),
        .instret    (instret)
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] instret;
    } exp_t;

    exp_t        exp_q[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] pc_m;
    logic [31:0] instret_m;
    logic        fault_m;

    function automatic logic [31:0] memword(input logic [31:0] a);
        if (a == 32'h0) return 32'h0050_0093;
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push_expected();
        exp_t e;
        e.pc      = pc_m;
        e.instr   = memword(pc_m);
        e.instret = instret_m;
        exp_q.push_back(e);
    endtask

    // Reference behaviour of one retirement.
    task automatic model_retire(input logic src, input logic [31:0] imm);
        logic [31:0] nxt;
        nxt = src ? pc_m + imm : pc_m + 32'd4;
        instret_m = instret_m + 32'd1;
        if (nxt[1:0] != 2'b00) fault_m = 1'b1;
        else pc_m = nxt;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        imem_ack = 1'b0; imem_rdata = '0; exec_ready = 1'b0; pc_src = 1'b0; imm_ext = '0;
        #1;
        check("rst_req", 32'(imem_req), 32'h0);
        check("rst_valid", 32'(instr_valid), 32'h0);
        check("rst_pc", pc, 32'h0);
        check("rst_instr", instr, 32'h0000_0013);
        check("rst_instret", instret, 32'h0);
        check("rst_fault", 32'(fault), 32'h0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        exp_q.delete();
        pc_m = 32'h0; instret_m = 32'h0; fault_m = 1'b0;
    endtask

    // One full instruction: wait for FETCH, ack after ack_wait cycles, hold ISSUE
    // ready_wait cycles (with stray acks), then retire with the given branch inputs.
    task automatic run_instr(input int ack_wait, input int ready_wait,
                             input logic src, input logic [31:0] imm);
        int guard;
        guard = 0;
        while (!imem_req && guard < 40) begin
            imem_ack = 1'($urandom_range(0, 1)); imem_rdata = $urandom;
            @(posedge clk); #1;
            guard++;
        end
        if (!imem_req) begin
            n_tests++; n_fail++;
            $display("FAIL fetch_wait: imem_req %0d after %0d cycles, required 1", imem_req, guard);
        end
        for (int i = 0; i < ack_wait; i++) begin
            imem_ack = 1'b0; imem_rdata = $urandom;
            @(posedge clk); #1;
        end
        imem_ack = 1'b1; imem_rdata = memword(imem_addr);
        push_expected();
        @(posedge clk); #1;
        for (int i = 0; i < ready_wait; i++) begin
            exec_ready = 1'b0; pc_src = 1'($urandom_range(0, 1)); imm_ext = $urandom;
            imem_ack = 1'($urandom_range(0, 1)); imem_rdata = $urandom;
            @(posedge clk); #1;
        end
        imem_ack = 1'b0;
        exec_ready = 1'b1; pc_src = src; imm_ext = imm;
        model_retire(src, imm);
        @(posedge clk); #1;
        exec_ready = 1'b0; pc_src = 1'($urandom_range(0, 1)); imm_ext = $urandom;
        check("retire_instret", instret, instret_m);
        check("retire_fault", 32'(fault), 32'(fault_m));
        check("retire_pc", pc, pc_m);
        if (fault_m) check("halt_req", 32'(imem_req), 32'h0);
        else check("next_addr", imem_addr, pc_m);
    endtask

    // Monitor: pop on each new issue, then require the word to hold while valid.
    initial begin
        logic prev_valid;
        exp_t cur;
        exp_t e;
        prev_valid = 1'b0;
        cur.pc = '0; cur.instr = '0; cur.instret = '0;
        forever begin
            @(negedge clk);
            if (rst_n && instr_valid) begin
                if (!prev_valid) begin
                    if (exp_q.size() == 0) begin
                        n_tests++; n_fail++;
                        $display("FAIL unexpected_issue: pc %h instr %h, required no issue", pc, instr);
                        cur.pc = pc; cur.instr = instr; cur.instret = instret;
                    end else begin
                        e = exp_q.pop_front();
                        check("issue_pc", pc, e.pc);
                        check("issue_instr", instr, e.instr);
                        check("issue_instret", instret, e.instret);
                        cur = e;
                    end
                end else begin
                    check("hold_pc", pc, cur.pc);
                    check("hold_instr", instr, cur.instr);
                    check("hold_instret", instret, cur.instret);
                end
                check("issue_req_low", 32'(imem_req), 32'h0);
            end
            prev_valid = rst_n && instr_valid;
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] off;
        #2;
        do_reset();

        // Zero-wait first fetch from address 0.
        check("rst_wait_req", 32'(imem_req), 32'h0);
        @(posedge clk); #1;
        check("fetch_req", 32'(imem_req), 32'h1);
        check("fetch_valid", 32'(instr_valid), 32'h0);
        imem_ack = 1'b1; imem_rdata = memword(imem_addr);
        push_expected();
        @(posedge clk); #1;
        imem_ack = 1'b0;
        // value seen by the 3rd rising edge after release
        check("valid_3rd_edge", 32'(instr_valid), 32'h1);
        check("first_instr", instr, 32'h0050_0093);
        exec_ready = 1'b1; pc_src = 1'b0; imm_ext = $urandom;
        model_retire(1'b0, 32'h0);
        @(posedge clk); #1;
        exec_ready = 1'b0;
        check("first_next_addr", imem_addr, 32'h4);
        check("first_instret", instret, 32'h1);

        for (int i = 0; i < 3; i++) run_instr(i, i, 1'b0, 32'h0);
        check("pc_at_10", pc, 32'h10);
        run_instr(1, 2, 1'b1, 32'hFFFF_FFF8);
        check("branch_back_addr", imem_addr, 32'h8);
        run_instr(0, 5, 1'b0, 32'h0);
        run_instr(0, 0, 1'b1, 32'hFFFF_FFF0);
        check("near_top_addr", imem_addr, 32'hFFFF_FFFC);
        run_instr(2, 0, 1'b0, 32'h0);
        check("wrap_addr", imem_addr, 32'h0);
        check("wrap_fault", 32'(fault), 32'h0);

        for (int i = 0; i < 120; i++) begin
            off = 32'($urandom_range(0, 63));
            run_instr($urandom_range(0, 4), $urandom_range(0, 3),
                      1'($urandom_range(0, 1)), (off - 32'd32) << 2);
        end

        // Reset in the middle of FETCH with an ack pending.
        check("pre_rst_req", 32'(imem_req), 32'h1);
        imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
        #2 rst_n = 1'b0;
        #1;
        check("async_req_drop", 32'(imem_req), 32'h0);
        check("async_pc", pc, 32'h0);
        @(posedge clk); #1;
        @(negedge clk);
        rst_n = 1'b1;
        exp_q.delete();
        pc_m = 32'h0; instret_m = 32'h0; fault_m = 1'b0;
        check("discard_instr", instr, 32'h0000_0013);
        check("discard_instret", instret, 32'h0);
        @(posedge clk); #1;
        check("rstwait_ack_ignored", instr, 32'h0000_0013);
        check("tmo_fetch_req", 32'(imem_req), 32'h1);
        imem_ack = 1'b0;

        // Ack timeout: 15 silent FETCH cycles are tolerated, the 16th halts.
        repeat (15) begin @(posedge clk); #1; end
        check("tmo_15_fault", 32'(fault), 32'h0);
        check("tmo_15_req", 32'(imem_req), 32'h1);
        @(posedge clk); #1;
        check("tmo_16_fault", 32'(fault), 32'h1);
        check("tmo_16_req", 32'(imem_req), 32'h0);
        for (int i = 0; i < 3; i++) begin
            imem_ack = 1'b1; imem_rdata = $urandom;
            @(posedge clk); #1;
            check("halt_instr", instr, 32'h0000_0013);
            check("halt_fault", 32'(fault), 32'h1);
            check("halt_req_low", 32'(imem_req), 32'h0);
            check("halt_valid_low", 32'(instr_valid), 32'h0);
        end
        imem_ack = 1'b0;

        // Misaligned branch target.
        do_reset();
        run_instr(0, 0, 1'b0, 32'h0);
        run_instr(1, 1, 1'b1, 32'h6);
        check("mis_fault", 32'(fault), 32'h1);
        check("mis_pc", pc, 32'h4);
        check("mis_instret", instret, 32'h2);
        for (int i = 0; i < 3; i++) begin
            imem_ack = 1'($urandom_range(0, 1)); exec_ready = 1'b1;
            @(posedge clk); #1;
            check("mis_req_low", 32'(imem_req), 32'h0);
            check("mis_valid_low", 32'(instr_valid), 32'h0);
        end
        imem_ack = 1'b0; exec_ready = 1'b0;

        @(negedge clk);
        check("queue_drain", 32'(exp_q.size()), 32'h0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/instr_fetch_unit.md
INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: program counter value after reset.
REQ-002 Parameter ACK_TIMEOUT, default 16: maximum cycles spent in FETCH waiting for imem_ack before fault.
REQ-003 Port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 Port rst_n  input  1  asynchronous, active-low reset.
REQ-005 Port imem_req  output  1  instruction memory read request.
REQ-006 Port imem_addr  output  32  instruction memory word address; always equals pc.
REQ-007 Port imem_ack  input  1  memory read data valid this cycle.
REQ-008 Port imem_rdata  input  32  memory read data.
REQ-009 Port instr  output  32  held instruction word presented to the control unit and datapath.
REQ-010 Port instr_valid  output  1  instr and pc are valid for execution.
REQ-011 Port pc  output  32  address of the instruction in instr.
REQ-012 Port exec_ready  input  1  execute stage consumes instr this cycle.
REQ-013 Port pc_src  input  1  branch-taken select from the control unit.
REQ-014 Port imm_ext  input  32  sign-extended branch offset from the immediate extender.
REQ-015 Port fault  output  1  sticky fetch fault: ack timeout or misaligned target.
REQ-016 Port instret  output  32  count of retired instructions.

Function
REQ-017 FSM states: RST_WAIT, FETCH, ISSUE, HALT; state encoding is free.
REQ-018 RST_WAIT lasts exactly one cycle after rst_n deassertion, then goes to FETCH; imem_req=0 in RST_WAIT.
REQ-019 FETCH: imem_req=1; on the first cycle with imem_ack=1, latch imem_rdata into instr and go to ISSUE next cycle.
REQ-020 imem_ack=1 coinciding with the first FETCH cycle is accepted (zero-wait memory supported).
REQ-021 imem_ack outside FETCH is ignored; instr does not change.
REQ-022 FETCH timeout counter clears on entry to FETCH; if ACK_TIMEOUT cycles elapse without imem_ack, go to HALT and set fault.
REQ-023 ISSUE: instr_valid=1, imem_req=0; state is held until exec_ready=1.
REQ-024 In ISSUE with exec_ready=1: pc_next = pc_src ? pc + imm_ext : pc + 4; sum is modulo 2^32 (wrap, no overflow flag); instret increments by 1 (wraps at 2^32).
REQ-025 pc_src and imm_ext are sampled only in the ISSUE and exec_ready cycle; otherwise they are don't-care.
REQ-026 If pc_next[1:0] != 2'b00, pc is not updated, instret still increments, state goes to HALT and fault is set.
REQ-027 Otherwise pc <= pc_next and the state returns to FETCH on the next cycle; minimum 2 cycles per instruction with zero-wait memory.
REQ-028 HALT: imem_req=0, instr_valid=0, fault=1; exit only via reset.
REQ-029 instr_valid is a registered decode of state ISSUE only; instr, pc, and instret remain stable whenever instr_valid=1.

Reset
REQ-030 rst_n=0 asynchronously forces state=RST_WAIT, pc=RESET_PC, instr=32'h0000_0013 (NOP), instret=0, fault=0, imem_req=0, instr_valid=0, and timeout counter=0.
REQ-031 Reset asserted mid-FETCH drops imem_req in the same cycle without waiting for a clock edge; a pending ack is discarded.

Verification
REQ-032 Zero-wait memory returning 32'h00500093 at address 0 with exec_ready=1 and pc_src=0 -> instr_valid is high on the 3rd edge after reset release, the next imem_addr is 4, and instret=1.
REQ-033 With pc=32'h10, pc_src=1, and imm_ext=32'hFFFF_FFF8 at retire -> the next imem_addr is 32'h08.
REQ-034 With pc=32'hFFFF_FFFC, pc_src=0, and retire -> pc wraps to 32'h0000_0000, with no fault.
REQ-035 imem_ack held low for 16 cycles in FETCH -> fault=1 and the state is HALT; a subsequent imem_ack is ignored.
REQ-036 With pc_src=1 and imm_ext=32'h6 at retire -> fault=1, pc unchanged, instret incremented, and imem_req stays 0.
REQ-037 exec_ready held low for 5 cycles in ISSUE -> instr, pc, and instr_valid are held constant; rst_n pulsed low mid-FETCH -> imem_req=0 immediately and pc=RESET_PC.
